// File: rtl/ifm_pkg.sv
// Shared definitions for the ifmap RAM read/write controllers: default
// widths and the tile-walker FSM state encoding.
package ifm_pkg;

  localparam int IFM_ADDR_WIDTH = 12;
  localparam int IFM_DATA_WIDTH = 10;
  localparam int IFM_DIM_WIDTH  = 8;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_DRAIN = 2'd2
  } ifm_state_e;

endpackage : ifm_pkg

// File: rtl/ifm_rd_ctrl_fifo.sv
// Small first-word-fall-through FIFO. The head entry is visible on rd_data
// whenever the FIFO is non-empty. Simultaneous write and read are legal at
// any occupancy; a write into a full FIFO is accepted only alongside a read.
module sync_fifo #(
  parameter int WIDTH = 11,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     wr_en,
  input  logic [WIDTH-1:0]         wr_data,
  input  logic                     rd_en,
  output logic [WIDTH-1:0]         rd_data,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty
);

  localparam int PW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PW-1:0]    wr_ptr_q;
  logic [PW-1:0]    rd_ptr_q;
  logic [PW:0]      count_q;
  logic             do_wr_s;
  logic             do_rd_s;

  // Qualify pushes and pops against current occupancy.
  always_comb begin
    do_rd_s = rd_en && (count_q != {(PW+1){1'b0}});
    do_wr_s = wr_en && ((count_q != (PW+1)'(DEPTH)) || do_rd_s);
  end

  // Storage is not reset: the empty flag masks stale entries.
  always_ff @(posedge clk) begin
    if (do_wr_s) begin
      mem_q[wr_ptr_q] <= wr_data;
    end
  end

  // Pointer and occupancy bookkeeping with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr_q <= {PW{1'b0}};
      rd_ptr_q <= {PW{1'b0}};
      count_q  <= {(PW+1){1'b0}};
    end else begin
      if (do_wr_s) begin
        wr_ptr_q <= wr_ptr_q + PW'(1);
      end
      if (do_rd_s) begin
        rd_ptr_q <= rd_ptr_q + PW'(1);
      end
      case ({do_wr_s, do_rd_s})
        2'b10:   count_q <= count_q + (PW+1)'(1);
        2'b01:   count_q <= count_q - (PW+1)'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  // Status and head-of-queue view.
  always_comb begin
    rd_data = mem_q[rd_ptr_q];
    count   = count_q;
    full    = (count_q == (PW+1)'(DEPTH));
    empty   = (count_q == {(PW+1){1'b0}});
  end

endmodule : sync_fifo

// File: rtl/ifm_rd_ctrl.sv
// Read-side initiator for the ifmap RAM. Walks one rectangular tile in
// row-major order, issuing at most one read per clock while credits allow,
// and streams the returned words (with a last flag) out of a small FIFO.
module ifm_rd_ctrl
  import ifm_pkg::*;
#(
  parameter int ADDR_WIDTH = IFM_ADDR_WIDTH,
  parameter int DATA_WIDTH = IFM_DATA_WIDTH,
  parameter int DIM_WIDTH  = IFM_DIM_WIDTH,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [ADDR_WIDTH-1:0] base_addr,
  input  logic [DIM_WIDTH-1:0]  num_rows,
  input  logic [DIM_WIDTH-1:0]  num_cols,
  input  logic [ADDR_WIDTH-1:0] row_stride,
  output logic                  busy,
  output logic                  done,
  output logic                  ram_read_req,
  output logic [ADDR_WIDTH-1:0] ram_read_addr,
  input  logic [DATA_WIDTH-1:0] ram_read_data,
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic [DATA_WIDTH-1:0] m_data,
  output logic                  m_last
);

  localparam int CW = $clog2(FIFO_DEPTH) + 1;
  localparam int OW = CW + 2;

  ifm_state_e            state_q;
  logic [DIM_WIDTH-1:0]  rows_q;
  logic [DIM_WIDTH-1:0]  cols_q;
  logic [DIM_WIDTH-1:0]  row_q;
  logic [DIM_WIDTH-1:0]  col_q;
  logic [ADDR_WIDTH-1:0] stride_q;
  logic [ADDR_WIDTH-1:0] row_base_q;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic                  busy_q;
  logic                  done_q;
  logic                  req_q;
  logic                  req_last_q;

  // Return tracker: one valid/last bit per RAM pipeline stage.
  logic                  v1_q;
  logic                  v2_q;
  logic                  l1_q;
  logic                  l2_q;

  logic [CW-1:0]         fifo_count_s;
  logic                  fifo_full_s;
  logic                  fifo_empty_s;
  logic [DATA_WIDTH:0]   fifo_rd_s;
  logic                  pop_s;
  logic                  head_last_s;
  logic [OW-1:0]         occ_s;
  logic                  credit_ok_s;
  logic                  col_end_s;
  logic                  is_last_s;

  // Credit check: a request decided now appears next cycle, so count every
  // word that will occupy the FIFO then (current entries net of this pop,
  // plus everything already committed to the RAM pipeline).
  always_comb begin
    pop_s       = !fifo_empty_s && m_ready;
    head_last_s = fifo_rd_s[DATA_WIDTH];
    occ_s       = OW'(fifo_count_s) + OW'(v2_q) + OW'(v1_q) + OW'(req_q) - OW'(pop_s);
    credit_ok_s = !fifo_full_s && (occ_s < OW'(FIFO_DEPTH));
    col_end_s   = (col_q == (cols_q - DIM_WIDTH'(1)));
    is_last_s   = col_end_s && (row_q == (rows_q - DIM_WIDTH'(1)));
  end

  // Tile-walker FSM with registered status and request outputs.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      rows_q     <= {DIM_WIDTH{1'b0}};
      cols_q     <= {DIM_WIDTH{1'b0}};
      row_q      <= {DIM_WIDTH{1'b0}};
      col_q      <= {DIM_WIDTH{1'b0}};
      stride_q   <= {ADDR_WIDTH{1'b0}};
      row_base_q <= {ADDR_WIDTH{1'b0}};
      addr_q     <= {ADDR_WIDTH{1'b0}};
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      req_q      <= 1'b0;
      req_last_q <= 1'b0;
    end else begin
      done_q     <= 1'b0;
      req_q      <= 1'b0;
      req_last_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          busy_q <= 1'b0;
          if (start) begin
            if ((num_rows != {DIM_WIDTH{1'b0}}) && (num_cols != {DIM_WIDTH{1'b0}})) begin
              rows_q     <= num_rows;
              cols_q     <= num_cols;
              stride_q   <= row_stride;
              row_base_q <= base_addr;
              row_q      <= {DIM_WIDTH{1'b0}};
              col_q      <= {DIM_WIDTH{1'b0}};
              busy_q     <= 1'b1;
              state_q    <= ST_ISSUE;
            end else begin
              // Empty tile: nothing to read, report completion at once.
              done_q <= 1'b1;
            end
          end
        end
        ST_ISSUE: begin
          if (credit_ok_s) begin
            req_q      <= 1'b1;
            req_last_q <= is_last_s;
            addr_q     <= row_base_q + ADDR_WIDTH'(col_q);
            if (col_end_s) begin
              col_q      <= {DIM_WIDTH{1'b0}};
              row_q      <= row_q + DIM_WIDTH'(1);
              row_base_q <= row_base_q + stride_q;
            end else begin
              col_q <= col_q + DIM_WIDTH'(1);
            end
            if (is_last_s) begin
              state_q <= ST_DRAIN;
            end
          end
        end
        ST_DRAIN: begin
          // busy stays high through the done cycle and drops in IDLE.
          if (pop_s && head_last_s) begin
            done_q  <= 1'b1;
            state_q <= ST_IDLE;
          end
        end
        default: begin
          state_q <= ST_IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  // Track outstanding reads through the 2-clock RAM latency.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      v1_q <= 1'b0;
      v2_q <= 1'b0;
      l1_q <= 1'b0;
      l2_q <= 1'b0;
    end else begin
      v1_q <= req_q;
      v2_q <= v1_q;
      l1_q <= req_last_q;
      l2_q <= l1_q;
    end
  end

  sync_fifo #(
    .WIDTH (DATA_WIDTH + 1),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .wr_en   (v2_q),
    .wr_data ({l2_q, ram_read_data}),
    .rd_en   (pop_s),
    .rd_data (fifo_rd_s),
    .count   (fifo_count_s),
    .full    (fifo_full_s),
    .empty   (fifo_empty_s)
  );

  // Drive the output stream from the FIFO head; zeros while empty so no
  // stale word is ever visible.
  always_comb begin
    busy          = busy_q;
    done          = done_q;
    ram_read_req  = req_q;
    ram_read_addr = addr_q;
    if (fifo_empty_s) begin
      m_valid = 1'b0;
      m_data  = {DATA_WIDTH{1'b0}};
      m_last  = 1'b0;
    end else begin
      m_valid = 1'b1;
      m_data  = fifo_rd_s[DATA_WIDTH-1:0];
      m_last  = head_last_s;
    end
  end

endmodule : ifm_rd_ctrl

// File: tb/tb_ifm_rd_ctrl.sv
// Self-checking bench for ifm_rd_ctrl: behavioural RAM, event monitor and
// a row-major tile model computed from base + r*stride + c.
module tb_ifm_rd_ctrl;

  localparam int AW = 12;
  localparam int DW = 10;
  localparam int NW = 8;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic [AW-1:0] base_addr = '0;
  logic [NW-1:0] num_rows = '0;
  logic [NW-1:0] num_cols = '0;
  logic [AW-1:0] row_stride = '0;
  logic          busy, done, ram_read_req, m_valid, m_last;
  logic [AW-1:0] ram_read_addr;
  logic [DW-1:0] ram_read_data;
  logic          m_ready = 1'b1;
  logic [DW-1:0] m_data;

  ifm_rd_ctrl dut (
    .clk(clk), .rst_n(rst_n), .start(start), .base_addr(base_addr),
    .num_rows(num_rows), .num_cols(num_cols), .row_stride(row_stride),
    .busy(busy), .done(done), .ram_read_req(ram_read_req),
    .ram_read_addr(ram_read_addr), .ram_read_data(ram_read_data),
    .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data), .m_last(m_last)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // Behavioural RAM: address registered, data valid 2 clocks after request.
  logic [DW-1:0] mem [1 << AW];
  logic [AW-1:0] p1_addr;
  logic          p1_v = 1'b0;
  always @(posedge clk) begin
    p1_addr       <= ram_read_addr;
    p1_v          <= ram_read_req;
    ram_read_data <= p1_v ? mem[p1_addr] : DW'($urandom);
  end

  // Monitor: observed events collected at the falling edge.
  logic [AW-1:0] req_addr_q[$];
  int            req_cyc_q[$];
  logic [DW-1:0] hs_data_q[$];
  logic          hs_last_q[$];
  int            hs_cyc_q[$];
  int            done_cyc_q[$];
  int            first_valid_cyc = -1;
  bit            busy_hist[int];
  int            stab_err = 0;
  logic          prev_v = 1'b0, prev_r = 1'b0, prev_rst = 1'b0, prev_l = 1'b0;
  logic [DW-1:0] prev_d = '0;

  always @(negedge clk) begin
    if (ram_read_req) begin
      req_addr_q.push_back(ram_read_addr);
      req_cyc_q.push_back(cyc);
    end
    if (m_valid && m_ready) begin
      hs_data_q.push_back(m_data);
      hs_last_q.push_back(m_last);
      hs_cyc_q.push_back(cyc);
    end
    if (m_valid && first_valid_cyc < 0) first_valid_cyc = cyc;
    if (done) done_cyc_q.push_back(cyc);
    busy_hist[cyc] = busy;
    if (rst_n && prev_rst && prev_v && !prev_r) begin
      if (!m_valid || m_data !== prev_d || m_last !== prev_l) stab_err++;
    end
    prev_v = m_valid; prev_r = m_ready; prev_d = m_data;
    prev_l = m_last; prev_rst = rst_n;
  end

  // Expected tile, built from the addressing rule.
  logic [AW-1:0] exp_addr_q[$];

  task automatic build_exp(input logic [AW-1:0] b, input int r, input int c,
                           input logic [AW-1:0] s);
    exp_addr_q.delete();
    for (int i = 0; i < r; i++)
      for (int j = 0; j < c; j++)
        exp_addr_q.push_back(AW'(int'(b) + i * int'(s) + j));
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic clear_mon();
    req_addr_q.delete(); req_cyc_q.delete();
    hs_data_q.delete(); hs_last_q.delete(); hs_cyc_q.delete();
    done_cyc_q.delete(); first_valid_cyc = -1;
  endtask

  // rmode: 0 ready=1, 1 random ready, 2 ready=0 for 20 cycles then 1.
  task automatic run_tile(input logic [AW-1:0] b, input logic [NW-1:0] r,
                          input logic [NW-1:0] c, input logic [AW-1:0] s,
                          input int rmode, input int glitch_at,
                          output int start_cyc, output int release_cyc,
                          output bit timeout);
    int n;
    clear_mon();
    base_addr = b; num_rows = r; num_cols = c; row_stride = s;
    start = 1'b1;
    m_ready = (rmode == 1) ? 1'($urandom_range(0, 1)) : (rmode == 2 ? 1'b0 : 1'b1);
    start_cyc = cyc;
    tick();
    start = 1'b0;
    n = 0; release_cyc = -1;
    while (done_cyc_q.size() == 0 && n < 2000) begin
      if (glitch_at == n) begin
        start = 1'b1; base_addr = AW'($urandom); row_stride = AW'($urandom);
        num_rows = r + 8'd1; num_cols = c + 8'd2;
      end else start = 1'b0;
      if (rmode == 1) m_ready = 1'($urandom_range(0, 1));
      else if (rmode == 2) begin
        m_ready = (n >= 19);
        if (n == 19) release_cyc = cyc;
      end else m_ready = 1'b1;
      tick(); n++;
    end
    start = 1'b0; m_ready = 1'b1;
    timeout = (done_cyc_q.size() == 0);
    repeat (3) tick();
  endtask

  task automatic test_reset();
    rst_n = 1'b0; repeat (2) tick();
    checks++;
    if ({busy, done, ram_read_req, ram_read_addr, m_valid, m_data, m_last} !== '0) begin
      failures++;
      $display("FAIL reset_values got busy=%b done=%b req=%b addr=%h valid=%b data=%h last=%b want all 0",
               busy, done, ram_read_req, ram_read_addr, m_valid, m_data, m_last);
    end
    rst_n = 1'b1; tick();
  endtask

  task automatic test_basic_tile();
    int sc, rc; bit to;
    build_exp(12'h010, 2, 3, 12'h020);
    run_tile(12'h010, 8'd2, 8'd3, 12'h020, 0, -1, sc, rc, to);
    checks++; if (to) begin failures++; $display("FAIL basic_timeout got no done want done"); end
    checks++;
    if (req_addr_q.size() != 6 || hs_data_q.size() != 6) begin
      failures++; $display("FAIL basic_count got req=%0d words=%0d want 6/6", req_addr_q.size(), hs_data_q.size());
    end else begin
      for (int i = 0; i < 6; i++) begin
        checks++;
        if (req_addr_q[i] !== exp_addr_q[i] || req_cyc_q[i] != req_cyc_q[0] + i ||
            hs_data_q[i] !== mem[exp_addr_q[i]] || hs_last_q[i] !== (i == 5)) begin
          failures++;
          $display("FAIL basic_elem%0d got addr=%h cyc=%0d data=%h last=%b want addr=%h cyc=%0d data=%h last=%b",
                   i, req_addr_q[i], req_cyc_q[i], hs_data_q[i], hs_last_q[i], exp_addr_q[i],
                   req_cyc_q[0] + i, mem[exp_addr_q[i]], (i == 5));
        end
      end
      checks++;
      if (done_cyc_q.size() != 1 || done_cyc_q[0] != hs_cyc_q[5] + 1) begin
        failures++; $display("FAIL basic_done got %0d pulses first=%0d want 1 at %0d",
                             done_cyc_q.size(), to ? -1 : done_cyc_q[0], hs_cyc_q[5] + 1);
      end
    end
  endtask

  task automatic test_latency();
    int sc, rc, d; bit to;
    run_tile(12'h123, 8'd1, 8'd1, 12'h000, 0, -1, sc, rc, to);
    checks++;
    if (to || req_cyc_q.size() != 1 || first_valid_cyc != req_cyc_q[0] + 3) begin
      failures++; $display("FAIL latency got valid_cyc=%0d reqs=%0d want req_cyc+3", first_valid_cyc, req_cyc_q.size());
    end else begin
      d = done_cyc_q[0];
      checks++;
      if (!busy_hist.exists(d + 1) || busy_hist[d] !== 1'b1 || busy_hist[d + 1] !== 1'b0) begin
        failures++; $display("FAIL latency_busy got busy@done=%b busy@done+1=%b want 1 then 0",
                             busy_hist[d], busy_hist[d + 1]);
      end
      checks++;
      if (hs_data_q.size() != 1 || hs_data_q[0] !== mem[12'h123] || hs_last_q[0] !== 1'b1) begin
        failures++; $display("FAIL latency_word got n=%0d want 1 word %h last", hs_data_q.size(), mem[12'h123]);
      end
    end
  endtask

  task automatic test_back_pressure();
    int sc, rc, pre; bit to;
    build_exp(12'h200, 1, 16, 12'h000);
    run_tile(12'h200, 8'd1, 8'd16, 12'h000, 2, -1, sc, rc, to);
    pre = 0;
    foreach (req_cyc_q[i]) if (req_cyc_q[i] < rc) pre++;
    checks++;
    if (pre != 4) begin failures++; $display("FAIL bp_stall got %0d reqs while stalled want 4", pre); end
    checks++;
    if (to || hs_data_q.size() != 16) begin
      failures++; $display("FAIL bp_count got %0d words want 16", hs_data_q.size());
    end else begin
      for (int i = 0; i < 16; i++) begin
        checks++;
        if (hs_data_q[i] !== mem[exp_addr_q[i]] || hs_last_q[i] !== (i == 15) || hs_cyc_q[i] < rc) begin
          failures++; $display("FAIL bp_word%0d got %h/%b want %h/%b", i, hs_data_q[i], hs_last_q[i],
                               mem[exp_addr_q[i]], (i == 15));
        end
      end
    end
  endtask

  task automatic test_wrap();
    int sc, rc; bit to;
    build_exp(12'hFFE, 1, 4, 12'h000);
    run_tile(12'hFFE, 8'd1, 8'd4, 12'h000, 0, -1, sc, rc, to);
    checks++;
    if (to || req_addr_q.size() != 4) begin
      failures++; $display("FAIL wrap_count got %0d reqs want 4", req_addr_q.size());
    end else begin
      for (int i = 0; i < 4; i++) begin
        checks++;
        if (req_addr_q[i] !== exp_addr_q[i] || hs_data_q[i] !== mem[exp_addr_q[i]]) begin
          failures++; $display("FAIL wrap_addr%0d got %h want %h", i, req_addr_q[i], exp_addr_q[i]);
        end
      end
    end
  endtask

  task automatic test_degenerate();
    int sc, rc; bit to;
    run_tile(12'h050, 8'd0, 8'd5, 12'h010, 0, -1, sc, rc, to);
    checks++;
    if (to || done_cyc_q[0] != sc + 1 || req_addr_q.size() != 0 || hs_data_q.size() != 0) begin
      failures++; $display("FAIL degen_rows0 got done=%0d reqs=%0d want done at %0d and 0 reqs",
                           to ? -1 : done_cyc_q[0], req_addr_q.size(), sc + 1);
    end
    run_tile(12'h050, 8'd3, 8'd0, 12'h010, 0, -1, sc, rc, to);
    checks++;
    if (to || done_cyc_q[0] != sc + 1 || req_addr_q.size() != 0 || busy_hist[sc + 1] !== 1'b0) begin
      failures++; $display("FAIL degen_cols0 got done=%0d reqs=%0d want done at %0d and 0 reqs",
                           to ? -1 : done_cyc_q[0], req_addr_q.size(), sc + 1);
    end
  endtask

  task automatic test_ignored_start();
    int sc, rc; bit to;
    build_exp(12'h3A0, 2, 4, 12'h040);
    run_tile(12'h3A0, 8'd2, 8'd4, 12'h040, 0, 3, sc, rc, to);
    checks++;
    if (to || req_addr_q.size() != 8 || hs_data_q.size() != 8 || done_cyc_q.size() != 1) begin
      failures++; $display("FAIL ignore_count got reqs=%0d words=%0d dones=%0d want 8/8/1",
                           req_addr_q.size(), hs_data_q.size(), done_cyc_q.size());
    end else begin
      for (int i = 0; i < 8; i++) begin
        checks++;
        if (req_addr_q[i] !== exp_addr_q[i] || hs_data_q[i] !== mem[exp_addr_q[i]]) begin
          failures++; $display("FAIL ignore_elem%0d got %h want %h", i, req_addr_q[i], exp_addr_q[i]);
        end
      end
    end
  endtask

  task automatic test_random_tiles();
    int sc, rc, n; bit to;
    logic [AW-1:0] b, s; logic [NW-1:0] r, c;
    for (int t = 0; t < 8; t++) begin
      b = AW'($urandom); s = AW'($urandom);
      r = NW'($urandom_range(1, 4)); c = NW'($urandom_range(1, 6));
      build_exp(b, int'(r), int'(c), s);
      n = exp_addr_q.size();
      run_tile(b, r, c, s, 1, -1, sc, rc, to);
      checks++;
      if (to || req_addr_q.size() != n || hs_data_q.size() != n ||
          done_cyc_q.size() != 1 || done_cyc_q[0] != hs_cyc_q[n - 1] + 1) begin
        failures++; $display("FAIL rand%0d_count got reqs=%0d words=%0d dones=%0d want %0d", t,
                             req_addr_q.size(), hs_data_q.size(), done_cyc_q.size(), n);
      end else begin
        for (int i = 0; i < n; i++) begin
          checks++;
          if (req_addr_q[i] !== exp_addr_q[i] || hs_data_q[i] !== mem[exp_addr_q[i]] ||
              hs_last_q[i] !== (i == n - 1)) begin
            failures++; $display("FAIL rand%0d_elem%0d got %h/%h/%b want %h/%h/%b", t, i, req_addr_q[i],
                                 hs_data_q[i], hs_last_q[i], exp_addr_q[i], mem[exp_addr_q[i]], (i == n - 1));
          end
        end
      end
    end
  endtask

  task automatic test_reset_mid();
    int sc, rc, n; bit to;
    clear_mon();
    base_addr = 12'h600; num_rows = 8'd1; num_cols = 8'd8; row_stride = 12'h000;
    m_ready = 1'b0; start = 1'b1; tick(); start = 1'b0;
    n = 0;
    while (req_addr_q.size() < 2 && n < 50) begin tick(); n++; end
    rst_n = 1'b0; tick(); rst_n = 1'b1;
    checks++;
    if ({busy, done, ram_read_req, ram_read_addr, m_valid, m_data, m_last} !== '0) begin
      failures++;
      $display("FAIL midreset_values got busy=%b done=%b req=%b addr=%h valid=%b data=%h last=%b want all 0",
               busy, done, ram_read_req, ram_read_addr, m_valid, m_data, m_last);
    end
    clear_mon(); m_ready = 1'b1;
    repeat (6) tick();
    checks++;
    if (hs_data_q.size() != 0 || done_cyc_q.size() != 0 || req_addr_q.size() != 0) begin
      failures++; $display("FAIL midreset_stale got words=%0d dones=%0d reqs=%0d want 0/0/0",
                           hs_data_q.size(), done_cyc_q.size(), req_addr_q.size());
    end
    build_exp(12'h0C0, 1, 3, 12'h000);
    run_tile(12'h0C0, 8'd1, 8'd3, 12'h000, 0, -1, sc, rc, to);
    checks++;
    if (to || hs_data_q.size() != 3) begin
      failures++; $display("FAIL midreset_newtile got %0d words want 3", hs_data_q.size());
    end else begin
      for (int i = 0; i < 3; i++) begin
        checks++;
        if (hs_data_q[i] !== mem[exp_addr_q[i]] || hs_last_q[i] !== (i == 2)) begin
          failures++; $display("FAIL midreset_word%0d got %h want %h", i, hs_data_q[i], mem[exp_addr_q[i]]);
        end
      end
    end
  endtask

  task automatic test_stability();
    checks++;
    if (stab_err != 0) begin
      failures++; $display("FAIL hold_stable got %0d changes under back-pressure want 0", stab_err);
    end
  endtask

  initial begin
    for (int i = 0; i < (1 << AW); i++) mem[i] = DW'($urandom);
    test_reset();
    test_basic_tile();
    test_latency();
    test_back_pressure();
    test_wrap();
    test_degenerate();
    test_ignored_start();
    test_random_tiles();
    test_reset_mid();
    test_stability();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule : tb_ifm_rd_ctrl
